// File: rtl/fifo_rd_if.sv
// Read-side bundle between the async FIFO read controller (slave) and the
// consumer/read-domain logic (master).
interface fifo_rd_if #(
    parameter int PTR_SZ = 2
);
    // Handshake: rinc is a read request. read_en is the single-cycle strobe
    // that actually consumes the entry at raddr. A request made while rempty=1
    // is refused and flagged as underflow; there is no backpressure otherwise.
    logic              rinc;
    logic [PTR_SZ:0]   rq2_waddr;
    logic              rempty;
    logic              read_en;
    logic [PTR_SZ-1:0] raddr;
    logic [PTR_SZ:0]   raddr_gray;
    logic [PTR_SZ:0]   rlevel;
    logic              ralmost_empty;
    logic              rerr_underflow;
    logic              state_dbg;

    modport master (
        output rinc, rq2_waddr,
        input  rempty, read_en, raddr, raddr_gray, rlevel,
               ralmost_empty, rerr_underflow, state_dbg
    );

    modport slave (
        input  rinc, rq2_waddr,
        output rempty, read_en, raddr, raddr_gray, rlevel,
               ralmost_empty, rerr_underflow, state_dbg
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-domain pointer/flag controller for a Gray-pointer async FIFO.
// Optional almost-empty flag is built only with FIFO_RD_ALMOST_EMPTY_EN defined.
module fifo_rd_ctrl #(
    parameter int PTR_SZ    = 2,
    parameter int RD_MODE   = 0,
    parameter int AE_THRESH = 1
) (
    input logic      clk,
    input logic      rst,
    fifo_rd_if.slave rif
);
    typedef enum logic {
        EMPTY  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t            state;
    logic [PTR_SZ:0]   rbin;
    logic [PTR_SZ:0]   rbin_next;
    logic [PTR_SZ:0]   rgray_q;
    logic [PTR_SZ:0]   rgray_next;
    logic [PTR_SZ:0]   wbin;
    logic [PTR_SZ:0]   rlevel_q;
    logic [PTR_SZ:0]   rlevel_next;
    logic              rempty_q;
    logic              empty_next;
    logic              err_q;
    logic              req;
    logic              read_en;

    generate
        if (RD_MODE == 1) begin : g_edge
            logic rinc_q;
            // Reset high so a request held through reset release is not an edge.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) rinc_q <= 1'b1;
                else      rinc_q <= rif.rinc;
            end
            assign req = rif.rinc & ~rinc_q;
        end else begin : g_level
            assign req = rif.rinc;
        end
    endgenerate

    assign read_en    = req & ~rempty_q;
    assign rbin_next  = rbin + {{PTR_SZ{1'b0}}, read_en};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;

    always_comb begin
        wbin         = '0;
        wbin[PTR_SZ] = rif.rq2_waddr[PTR_SZ];
        for (int i = PTR_SZ - 1; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ rif.rq2_waddr[i];
        end
    end

    // Compare the post-read pointer with the current write pointer so a last
    // read coinciding with a write advance leaves the FIFO non-empty.
    assign empty_next  = (rgray_next == rif.rq2_waddr);
    assign rlevel_next = wbin - rbin_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= EMPTY;
            rbin     <= '0;
            rgray_q  <= '0;
            rempty_q <= 1'b1;
            rlevel_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rbin     <= rbin_next;
            rgray_q  <= rgray_next;
            rempty_q <= empty_next;
            rlevel_q <= rlevel_next;
            if (req && rempty_q) err_q <= 1'b1;
            case (state)
                EMPTY:   if (!empty_next) state <= ACTIVE;
                ACTIVE:  if (empty_next)  state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    localparam logic [PTR_SZ+1:0] AE_T = AE_THRESH[PTR_SZ+1:0];
    logic ae_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ae_q <= 1'b1;
        else      ae_q <= ({1'b0, rlevel_next} <= AE_T);
    end
    assign rif.ralmost_empty = ae_q;
`else
    assign rif.ralmost_empty = 1'b0;
`endif

    assign rif.rempty         = rempty_q;
    assign rif.read_en        = read_en;
    assign rif.raddr          = rbin[PTR_SZ-1:0];
    assign rif.raddr_gray     = rgray_q;
    assign rif.rlevel         = rlevel_q;
    assign rif.rerr_underflow = err_q;
    assign rif.state_dbg      = state;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl (PTR_SZ=2): level-mode instance u_lvl and
// edge-mode instance u_edge, expected read addresses kept in a scoreboard queue.
module tb_fifo_rd_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    localparam bit AE_ON = 1'b1;
`else
    localparam bit AE_ON = 1'b0;
`endif

    fifo_rd_if #(.PTR_SZ(2)) a_if ();
    fifo_rd_if #(.PTR_SZ(2)) b_if ();

    fifo_rd_ctrl #(.PTR_SZ(2), .RD_MODE(0), .AE_THRESH(1)) u_lvl (
        .clk(clk), .rst(rst), .rif(a_if.slave)
    );
    fifo_rd_ctrl #(.PTR_SZ(2), .RD_MODE(1), .AE_THRESH(1)) u_edge (
        .clk(clk), .rst(rst), .rif(b_if.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [1:0] exp_q[$];
    int cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Consume one expected read from the scoreboard and compare with the DUT.
    task automatic pop_read(input string tag);
        logic [1:0] e;
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_qempty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_read_en"}, {31'd0, a_if.read_en}, 32'd1);
            check({tag, "_raddr"}, {30'd0, a_if.raddr}, {30'd0, e});
        end
    endtask

    initial begin
        rst            = 1'b0;
        a_if.rinc      = 1'b0;
        a_if.rq2_waddr = 3'b000;
        b_if.rinc      = 1'b1;
        b_if.rq2_waddr = 3'b000;
        #12;
        check("rst_rempty", {31'd0, a_if.rempty}, 32'd1);
        check("rst_raddr", {30'd0, a_if.raddr}, 32'd0);
        check("rst_gray", {29'd0, a_if.raddr_gray}, 32'd0);
        check("rst_rlevel", {29'd0, a_if.rlevel}, 32'd0);
        check("rst_err", {31'd0, a_if.rerr_underflow}, 32'd0);
        check("rst_state", {31'd0, a_if.state_dbg}, 32'd0);
        check("rst_ae", {31'd0, a_if.ralmost_empty}, {31'd0, AE_ON});
        a_if.rinc = 1'b1;
        #1;
        check("rst_read_en", {31'd0, a_if.read_en}, 32'd0);
        a_if.rinc = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();

        // Edge mode: rinc high through reset release must not read.
        b_if.rq2_waddr = 3'b010;
        step();
        check("edge_rempty", {31'd0, b_if.rempty}, 32'd0);
        check("edge_rlevel3", {29'd0, b_if.rlevel}, 32'd3);
        check("edge_held_no_read", {31'd0, b_if.read_en}, 32'd0);
        b_if.rinc = 1'b0;
        step();
        b_if.rinc = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (b_if.read_en) cnt++;
            step();
        end
        b_if.rinc = 1'b0;
        check("edge_pulses", cnt, 32'd1);
        check("edge_rlevel2", {29'd0, b_if.rlevel}, 32'd2);

        // Full drain of four entries in level mode.
        a_if.rq2_waddr = 3'b110;
        step();
        check("fill_rempty", {31'd0, a_if.rempty}, 32'd0);
        check("fill_rlevel", {29'd0, a_if.rlevel}, 32'd4);
        check("fill_state", {31'd0, a_if.state_dbg}, 32'd1);
        check("fill_ae", {31'd0, a_if.ralmost_empty}, 32'd0);
        a_if.rinc = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(k[1:0]);
        for (int k = 0; k < 4; k++) begin
            pop_read("drain");
            step();
            check("drain_rlevel", {29'd0, a_if.rlevel}, 32'(3 - k));
            check("drain_ae", {31'd0, a_if.ralmost_empty}, {31'd0, AE_ON && ((3 - k) <= 1)});
        end
        check("drain_rempty", {31'd0, a_if.rempty}, 32'd1);
        check("drain_gray", {29'd0, a_if.raddr_gray}, 32'b110);
        check("drain_state", {31'd0, a_if.state_dbg}, 32'd0);
        #1;
        check("uf_read_en", {31'd0, a_if.read_en}, 32'd0);
        check("uf_err_before", {31'd0, a_if.rerr_underflow}, 32'd0);
        step();
        check("uf_err", {31'd0, a_if.rerr_underflow}, 32'd1);
        check("uf_raddr", {30'd0, a_if.raddr}, 32'd0);
        a_if.rinc = 1'b0;
        step();
        check("uf_sticky", {31'd0, a_if.rerr_underflow}, 32'd1);

        // Wrap: advance rbin to 7, then one entry across the wrap.
        a_if.rq2_waddr = 3'b100;
        step();
        check("wrap_rlevel3", {29'd0, a_if.rlevel}, 32'd3);
        a_if.rinc = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(k[1:0]);
        for (int k = 0; k < 3; k++) begin
            pop_read("pre_wrap");
            step();
        end
        a_if.rinc = 1'b0;
        check("rbin7_raddr", {30'd0, a_if.raddr}, 32'd3);
        check("rbin7_gray", {29'd0, a_if.raddr_gray}, 32'b100);
        a_if.rq2_waddr = 3'b000;
        step();
        check("wrap_rempty0", {31'd0, a_if.rempty}, 32'd0);
        check("wrap_rlevel1", {29'd0, a_if.rlevel}, 32'd1);
        a_if.rinc = 1'b1;
        exp_q.push_back(2'd3);
        pop_read("wrap");
        step();
        a_if.rinc = 1'b0;
        check("wrap_gray", {29'd0, a_if.raddr_gray}, 32'b000);
        check("wrap_raddr", {30'd0, a_if.raddr}, 32'd0);
        check("wrap_rempty1", {31'd0, a_if.rempty}, 32'd1);

        // Reset in the middle of a burst.
        a_if.rq2_waddr = 3'b010;
        step();
        a_if.rinc = 1'b1;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        pop_read("burst");
        step();
        pop_read("burst");
        step();
        check("burst_raddr", {30'd0, a_if.raddr}, 32'd2);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_raddr", {30'd0, a_if.raddr}, 32'd0);
        check("mid_rst_gray", {29'd0, a_if.raddr_gray}, 32'd0);
        check("mid_rst_rempty", {31'd0, a_if.rempty}, 32'd1);
        check("mid_rst_err", {31'd0, a_if.rerr_underflow}, 32'd0);
        check("mid_rst_read_en", {31'd0, a_if.read_en}, 32'd0);
        a_if.rinc      = 1'b0;
        a_if.rq2_waddr = 3'b001;
        @(negedge clk);
        rst = 1'b1;
        step();
        check("post_rst_rempty", {31'd0, a_if.rempty}, 32'd0);
        check("post_rst_rlevel", {29'd0, a_if.rlevel}, 32'd1);

        // Last read together with a write-pointer advance.
        a_if.rinc = 1'b1;
        exp_q.push_back(2'd0);
        pop_read("first_after_rst");
        a_if.rq2_waddr = 3'b011;
        step();
        check("simul_rempty", {31'd0, a_if.rempty}, 32'd0);
        check("simul_rlevel", {29'd0, a_if.rlevel}, 32'd1);
        check("simul_raddr", {30'd0, a_if.raddr}, 32'd1);
        exp_q.push_back(2'd1);
        pop_read("simul_next");
        step();
        a_if.rinc = 1'b0;
        check("end_rempty", {31'd0, a_if.rempty}, 32'd1);
        check("end_rlevel", {29'd0, a_if.rlevel}, 32'd0);
        check("end_gray", {29'd0, a_if.raddr_gray}, 32'b011);
        check("end_err", {31'd0, a_if.rerr_underflow}, 32'd0);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter PTR_SZ, default 2, meaning address width; FIFO depth is 2^PTR_SZ entries.
REQ-002 SHALL have parameter RD_MODE, default 0, meaning 0 = level-triggered reads and 1 = rising-edge-triggered reads on rinc.
REQ-003 SHALL have parameter AE_THRESH, default 1, meaning the almost-empty threshold in entries, range 0..2^PTR_SZ.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port rinc, input, 1 bit: read request.
REQ-007 SHALL have port rq2_waddr, input, PTR_SZ+1 bits: Gray-coded write pointer, already synchronised into clk.
REQ-008 SHALL have port rempty, output, 1 bit: FIFO empty, registered.
REQ-009 SHALL have port read_en, output, 1 bit: combinational memory read strobe for this cycle.
REQ-010 SHALL have port raddr, output, PTR_SZ bits: memory read address.
REQ-011 SHALL have port raddr_gray, output, PTR_SZ+1 bits: registered Gray read pointer, for the write-domain synchroniser.
REQ-012 SHALL have port rlevel, output, PTR_SZ+1 bits: registered occupancy, 0..2^PTR_SZ.
REQ-013 SHALL have port ralmost_empty, output, 1 bit: registered almost-empty flag.
REQ-014 SHALL have port rerr_underflow, output, 1 bit: sticky underflow flag.

Function
REQ-015 SHALL keep a PTR_SZ+1-bit binary read pointer rbin; raddr = rbin[PTR_SZ-1:0]; all 2^PTR_SZ entries SHALL be usable (extra MSB distinguishes wrap).
REQ-016 SHALL form the request req = rinc when RD_MODE=0, and req = rinc & ~rinc_q when RD_MODE=1, where rinc_q is rinc registered one cycle.
REQ-017 SHALL drive read_en = req & ~rempty; rbin SHALL increment by 1 on a clock edge with read_en=1, wrapping from 2^(PTR_SZ+1)-1 to 0.
REQ-018 SHALL register raddr_gray <= (rbin_next>>1)^rbin_next and rempty <= (gray of rbin_next == rq2_waddr), giving one-cycle latency from a pointer change to the flag.
REQ-019 SHALL convert rq2_waddr Gray to binary wbin and register rlevel <= (wbin - rbin_next) mod 2^(PTR_SZ+1).
REQ-020 SHALL treat a simultaneous last read and rq2_waddr advance correctly: rempty is computed from the post-read pointer against the current rq2_waddr.
REQ-021 SHALL set rerr_underflow on any edge where req=1 and rempty=1; it SHALL stay set until reset; the pointer SHALL NOT move.
REQ-022 SHALL use a state machine: EMPTY (rempty=1), ACTIVE (rempty=0); EMPTY->ACTIVE when the next-state empty compare is false; ACTIVE->EMPTY when it is true; the state SHALL be consistent with rempty every cycle.

Reset
REQ-023 SHALL, while rst=0, asynchronously force rbin=0, raddr=0, raddr_gray=0, rempty=1, rlevel=0, ralmost_empty=1, rerr_underflow=0, state EMPTY, and read_en=0.
REQ-024 SHALL reset rinc_q to 1, so that in edge mode a rinc held high through reset release produces no read.
REQ-025 SHALL accept reset assertion mid-burst; the first read after release SHALL be from address 0.

Configuration
REQ-026 SHALL compile the almost-empty logic only when macro FIFO_RD_ALMOST_EMPTY_EN is defined: ralmost_empty <= (rlevel_next <= AE_THRESH).
REQ-027 SHALL, without FIFO_RD_ALMOST_EMPTY_EN, tie ralmost_empty to constant 0 and generate no threshold logic.

Verification (PTR_SZ=2)
REQ-028 SHALL cover reset: with rst=0, expect rempty=1, raddr=0, raddr_gray=0, rlevel=0, read_en=0, and rerr_underflow=0.
REQ-029 SHALL cover full drain: set rq2_waddr=3'b110 (binary 4) and expect rempty=0 and rlevel=4 next cycle; hold rinc=1 (RD_MODE=0) for 4 cycles and expect raddr 0,1,2,3, then rempty=1, rlevel=0, and raddr_gray=3'b110.
REQ-030 SHALL cover wrap: with rbin=7 (gray 100) and one entry available, one read gives raddr_gray=3'b000 and raddr=0.
REQ-031 SHALL cover edge mode: with RD_MODE=1, rlevel=3, and rinc held high 3 cycles, expect exactly one read_en pulse and rlevel=2.
REQ-032 SHALL cover underflow: with rinc=1 while rempty=1, expect read_en=0, raddr unchanged, and rerr_underflow=1 until rst=0.
REQ-033 SHALL cover the macro: with FIFO_RD_ALMOST_EMPTY_EN defined and AE_THRESH=1, expect ralmost_empty=1 at rlevel=1 and 0 at rlevel=2; without the macro, ralmost_empty stays 0.
